// File: rtl/fetch_stage.sv
// RV32 IF stage plus IF/ID register: single-outstanding instruction fetch with kill/hold handling.
// Optional FETCH_PERF_CNT_EN adds delivery and bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        stallf_i,
  input  logic        stalld_i,
  input  logic        flushd_i,
  input  logic        pcsrce_i,
  input  logic [31:0] pctargete_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instrd_o,
  output logic [31:0] pcd_o,
  output logic [31:0] pcplus4d_o,
  output logic        validd_o,
  output logic        fetch_busy_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_bubble_o
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pcf_reg, pcf_next;
  logic        kill_reg, kill_next;
  logic [31:0] hold_reg, hold_next;
  logic        deliver;
  logic [31:0] deliver_data;
  logic        hold_stall;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= ST_BOOT;
      pcf_reg   <= RESET_PC;
      kill_reg  <= 1'b0;
      hold_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      pcf_reg   <= pcf_next;
      kill_reg  <= kill_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pcf_next     = pcf_reg;
    kill_next    = kill_reg;
    hold_next    = hold_reg;
    deliver      = 1'b0;
    deliver_data = imem_rdata_i;
    // PCF must not advance under StallF, so either stall blocks delivery
    hold_stall   = stalld_i | stallf_i;

    case (state_reg)
      ST_BOOT: state_next = ST_REQ;
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (kill_reg) begin
            kill_next  = 1'b0;
            state_next = ST_REQ;
          end else if (hold_stall) begin
            hold_next  = imem_rdata_i;
            state_next = ST_HOLD;
          end else begin
            deliver    = 1'b1;
            state_next = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        deliver_data = hold_reg;
        if (!hold_stall) begin
          deliver    = 1'b1;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_BOOT;
    endcase

    if (deliver) pcf_next = pcf_reg + 32'd4;

    // A redirect overrides everything; a fetch already in flight is marked stale via kill
    if (pcsrce_i) begin
      pcf_next = {pctargete_i[31:2], 2'b00};
      deliver  = 1'b0;
      case (state_reg)
        ST_REQ: begin
          kill_next  = 1'b1;
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            kill_next  = 1'b0;
            state_next = ST_REQ;
          end else begin
            kill_next  = 1'b1;
            state_next = ST_WAIT;
          end
        end
        default: state_next = ST_REQ;
      endcase
    end
  end

  assign imem_req_o   = (state_reg == ST_REQ);
  assign imem_addr_o  = pcf_reg;
  assign fetch_busy_o = (state_reg == ST_WAIT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instrd_o   <= NOP_INSTR;
      pcd_o      <= 32'h0;
      pcplus4d_o <= 32'h0;
      validd_o   <= 1'b0;
    end else if (flushd_i) begin
      instrd_o <= NOP_INSTR;
      validd_o <= 1'b0;
    end else if (stalld_i) begin
      instrd_o <= instrd_o;
    end else if (deliver) begin
      instrd_o   <= deliver_data;
      pcd_o      <= pcf_reg;
      pcplus4d_o <= pcf_reg + 32'd4;
      validd_o   <= 1'b1;
    end else begin
      instrd_o <= NOP_INSTR;
      validd_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic bubble_load;
  assign bubble_load = flushd_i | (!stalld_i & !deliver);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_fetched_o <= 32'h0;
      perf_bubble_o  <= 32'h0;
    end else begin
      if (!flushd_i && !stalld_i && deliver) perf_fetched_o <= perf_fetched_o + 32'd1;
      if (bubble_load) perf_bubble_o <= perf_bubble_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Responses are only legal while a fetch is outstanding
  rvalid_in_wait: assert property (@(posedge clk_i) disable iff (!rstn_i)
    imem_rvalid_i |-> state_reg == ST_WAIT);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: transaction-level memory and IF/ID reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int ANY = 0, ON_REQ = 1, ON_RESP = 2;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        stallf_i, stalld_i, flushd_i, pcsrce_i;
  logic [31:0] pctargete_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instrd_o, pcd_o, pcplus4d_o;
  logic        validd_o, fetch_busy_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_bubble_o;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i(clk), .rstn_i(rstn_i), .stallf_i(stallf_i), .stalld_i(stalld_i),
    .flushd_i(flushd_i), .pcsrce_i(pcsrce_i), .pctargete_i(pctargete_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instrd_o(instrd_o), .pcd_o(pcd_o), .pcplus4d_o(pcplus4d_o),
    .validd_o(validd_o), .fetch_busy_o(fetch_busy_o)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched_o), .perf_bubble_o(perf_bubble_o)
`endif
  );

  int tests_run = 0, tests_failed = 0;

  // Reference state: architectural PC, hold buffer, expected IF/ID, outstanding fetch
  logic [31:0] m_pc, m_avail_data, m_instr, m_pcd, m_pcp4, o_addr;
  logic        m_avail, m_valid, o_busy, o_stale;
  int          o_cnt, cyc, first_req, first_valid, n_deliver;
  logic [31:0] m_fetched, m_bubble;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[12:0], a[31:13]} ^ 32'h0050_0093;
  endfunction

  task automatic model_clear();
    m_pc = 32'h0; m_avail = 1'b0; m_avail_data = 32'h0;
    m_instr = NOP; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
    o_busy = 1'b0; o_stale = 1'b0; o_cnt = 0; o_addr = 32'h0;
    m_fetched = 32'h0; m_bubble = 32'h0;
    first_req = -1; first_valid = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    stallf_i = 1'b0; stalld_i = 1'b0; flushd_i = 1'b0; pcsrce_i = 1'b0;
    pctargete_i = 32'h0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_instr", instrd_o, NOP);
    check("rst_valid", {31'b0, validd_o}, 32'h0);
    check("rst_req", {31'b0, imem_req_o}, 32'h0);
    check("rst_busy", {31'b0, fetch_busy_o}, 32'h0);
    check("rst_pcd", pcd_o, 32'h0);
    rstn_i = 1'b1;
    // The boot cycle following release loads one bubble into IF/ID
    m_bubble = 32'h1;
    cyc = 1;
  endtask

  task automatic step(input logic st, input logic fl, input logic ps, input logic [31:0] tg,
                      input int maxlat, input int mode, output logic applied);
    logic resp, dlv, ps_eff;
    logic [31:0] d;
    @(negedge clk);
    check("instrd", instrd_o, m_instr);
    check("validd", {31'b0, validd_o}, {31'b0, m_valid});
    check("pcd", pcd_o, m_pcd);
    check("pcplus4d", pcplus4d_o, m_pcp4);
    check("busy", {31'b0, fetch_busy_o}, {31'b0, o_busy});
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched_o, m_fetched);
    check("perf_bubble", perf_bubble_o, m_bubble);
`endif
    if (imem_req_o) begin
      check("req_addr", imem_addr_o, m_pc);
      check("req_idle", {31'b0, o_busy | m_avail}, 32'h0);
      if (first_req < 0) first_req = cyc;
    end
    if (validd_o && first_valid < 0) first_valid = cyc;

    resp = o_busy && (o_cnt == 0);
    ps_eff = ps && (mode == ANY || (mode == ON_REQ && imem_req_o) || (mode == ON_RESP && resp));
    applied = ps_eff;
    stalld_i = st; stallf_i = st; flushd_i = fl; pcsrce_i = ps_eff; pctargete_i = tg;
    imem_rvalid_i = resp;
    imem_rdata_i  = resp ? word(o_addr) : $urandom;

    dlv = 1'b0;
    d = imem_rdata_i;
    if (ps_eff) begin
      m_avail = 1'b0;
    end else if (m_avail || (resp && !o_stale)) begin
      d = m_avail ? m_avail_data : imem_rdata_i;
      if (!st) dlv = 1'b1;
      else begin
        m_avail = 1'b1;
        m_avail_data = d;
      end
    end

    if (fl) begin
      m_instr = NOP; m_valid = 1'b0; m_bubble++;
    end else if (st) begin
      // IF/ID holds
    end else if (dlv) begin
      m_instr = d; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_fetched++;
    end else begin
      m_instr = NOP; m_valid = 1'b0; m_bubble++;
    end

    if (dlv) begin
      $display("[TB] cycle %0d deliver pc=%h instr=%h flush=%0b", cyc, m_pc, d, fl);
      m_avail = 1'b0;
      m_pc = m_pc + 32'd4;
      n_deliver++;
    end
    if (ps_eff) m_pc = tg & ~32'h3;

    if (resp) o_busy = 1'b0;
    else if (o_busy) begin
      o_cnt--;
      if (ps_eff) o_stale = 1'b1;
    end
    if (imem_req_o) begin
      o_busy = 1'b1; o_addr = imem_addr_o; o_stale = ps_eff;
      o_cnt = $urandom_range(maxlat - 1, 0);
    end
    cyc++;
  endtask

  task automatic redirect_when(input logic [31:0] tg, input int mode);
    logic ap;
    ap = 1'b0;
    for (int i = 0; i < 12 && !ap; i++) step(1'b0, 1'b0, 1'b1, tg, 1, mode, ap);
    check("redirect_applied", {31'b0, ap}, 32'h1);
  endtask

  initial begin
    logic ap;
    int d0;
    rstn_i = 1'b0;
    n_deliver = 0;
    cyc = 0;
    do_reset();

    // Clean run: latency 1, no hazards
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1, ANY, ap);
    check("first_req_cycle", first_req, 32'd1);
    check("first_valid_cycle", first_valid, 32'd3);
    check("throughput", n_deliver, 32'd10);

    // Stall for three cycles across a response, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1, ANY, ap);
    d0 = n_deliver;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1, ANY, ap);
    check("stall_resume", (n_deliver - d0) >= 1, 32'h1);

    // Redirect during request, during response, and near the top of memory
    redirect_when(32'h100, ON_REQ);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1, ANY, ap);
    redirect_when(32'h203, ON_RESP);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1, ANY, ap);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1, ANY, ap);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1, ANY, ap);
    redirect_when(32'hFFFF_FFF8, ON_REQ);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1, ANY, ap);

    // Randomized hazards and memory latency, with an asynchronous reset in the middle
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1500; i++) begin
        step(($urandom % 5) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0,
             ($urandom % 4 == 0) ? 32'hFFFF_FFF0 | $urandom_range(15, 0) : $urandom,
             3, ANY, ap);
      end
      if (pass == 0) do_reset();
    end

    check("progress", n_deliver > 200, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register of the RV32 pipeline; sits directly upstream of the hazard unit and decode.
- Owns PCF and issues one-outstanding-request fetches to instruction memory.
- Consumes StallF/StallD/FlushD and the execute-stage redirect (PCSrcE, PCTargetE); delivers instrD/pcD/pcplus4D or a NOP bubble to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, encoding driven as a bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- stallf_i  in  1  StallF from hazard unit: hold PCF.
- stalld_i  in  1  StallD from hazard unit: hold IF/ID.
- flushd_i  in  1  FlushD from hazard unit: IF/ID becomes bubble.
- pcsrce_i  in  1  taken branch/jump in EX.
- pctargete_i  in  32  redirect target.
- imem_req_o  out  1  fetch request, one-cycle pulse.
- imem_addr_o  out  32  fetch address, equals PCF while imem_req_o=1.
- imem_rvalid_i  in  1  response valid, earliest one cycle after request, exactly one per request.
- imem_rdata_i  in  32  instruction word.
- instrd_o  out  32  IF/ID instruction.
- pcd_o  out  32  IF/ID PC.
- pcplus4d_o  out  32  IF/ID PC+4.
- validd_o  out  1  IF/ID holds a real instruction.
- fetch_busy_o  out  1  1 when state is WAIT.

Behaviour:
- Reset (async, rstn_i=0): PCF=RESET_PC, state=BOOT, kill=0, imem_req_o=0, instrd_o=NOP_INSTR, pcd_o=0, pcplus4d_o=0, validd_o=0, fetch_busy_o=0, hold buffer empty. A reset mid-request drops the request and discards any later response.
- FSM states:
  - BOOT: no request; next state REQ.
  - REQ: imem_req_o=1, imem_addr_o=PCF; next state WAIT unconditionally.
  - WAIT: no request. On imem_rvalid_i: if kill=1, discard the data, clear kill, next state REQ. Otherwise deliver, or go to HOLD if stalld_i=1.
  - HOLD: the response is stored in a 1-entry buffer. Deliver when stalld_i=0, next state REQ.
- Deliver: IF/ID <= {data, PCF, PCF+4}, validd_o=1, PCF <= PCF+4. Arithmetic is mod 2^32, so 0xFFFF_FFFC wraps to 0.
- Throughput: 2 cycles per instruction when unstalled and memory latency is 1. Request in cycle N, rvalid in N+1, IF/ID loaded at the end of N+1.
- IF/ID update priority, per cycle:
  1. flushd_i loads a bubble (NOP_INSTR, validd_o=0; pcd_o and pcplus4d_o hold).
  2. Otherwise stalld_i holds all IF/ID fields.
  3. Otherwise a delivery loads the instruction.
  4. Otherwise a bubble is loaded, so no instruction is ever issued twice.
- stallf_i: PCF never advances while stallf_i=1 (StallF and StallD are asserted together).
- Redirect (pcsrce_i=1) overrides all else. PCF <= {pctargete_i[31:2],2'b00} in any state, and there is no delivery that cycle.
  - BOOT: next state REQ.
  - REQ (a stale request is in flight): kill=1, next state WAIT.
  - WAIT without rvalid: kill=1, stay in WAIT.
  - WAIT with rvalid: discard, next state REQ.
  - HOLD: drop the buffer, next state REQ.
- Redirect and stall in the same cycle: the redirect wins on PCF; stalld_i still holds IF/ID unless flushd_i is also set.
- A response arriving in BOOT/REQ/HOLD is a protocol error, ignored; assertion-only.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched_o[31:0] (count of deliveries) and perf_bubble_o[31:0] (count of cycles IF/ID loaded a bubble, including flushes).
  - Both reset to 0 and wrap at 2^32.
  - They increment in the same cycle IF/ID is written.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory latency 1, no hazards -> first req at cycle 1 with addr 0x0. instrd_o=word@0x0, validd_o=1 at cycle 3. Next req addr 0x4, one delivery every 2 cycles.
- stalld_i=stallf_i=1 for 3 cycles while WAIT receives rvalid with 0x00500093 -> state HOLD, IF/ID unchanged. Delivery of 0x00500093 the cycle after stall drops; PCF advances by 4.
- pcsrce_i=1, pctargete_i=0x100 during REQ at PCF=0x8 -> kill set. Response for 0x8 discarded. Next req addr 0x100, validd_o=0 until 0x100 is delivered.
- pcsrce_i=1 coinciding with rvalid in WAIT, target 0x203 -> data dropped, next req addr 0x200.
- flushd_i=1 and stalld_i=1 together -> instrd_o=0x00000013, validd_o=0.
- PCF=0xFFFF_FFFC delivered -> pcplus4d_o=0x0, next req addr 0x0. With FETCH_PERF_CNT_EN, perf_fetched_o increments by exactly 1 per delivery.
